// File: rtl/float_pkg.sv
// Shared float definitions: default widths, normaliser state encoding, flag indices
// and special-value constants reused by the adder and multiplier.
package float_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int FRAC_W_DEF = 23;
    localparam int IN_W_DEF   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UF   = 2;
    localparam int FLG_INX  = 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

endpackage

// File: rtl/float_normalize_if.sv
// Handshake bundle between the float adder, the normalise/round stage and its consumer.
// slave is the normaliser's view; master is the producer/consumer view.
interface float_normalize_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int IN_W   = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [EXP_W-1:0]        in_exp;
    logic [IN_W-1:0]         in_mant;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out;
    logic [3:0]              out_flags;

    modport slave (
        input  in_valid, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out, out_flags
    );

    modport master (
        output in_valid, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out, out_flags
    );
endinterface

// File: rtl/float_round_pack.sv
// Combinational round-to-nearest-even, overflow/underflow detection and IEEE-754 packing.
// Expects a normalised mantissa with hidden bit at mant[FRAC_W]; denormals flush to zero.
module float_round_pack
    import float_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] e,
    input  logic [FRAC_W:0]         mant,
    input  logic                    g,
    input  logic                    s,
    output logic [EXP_W+FRAC_W:0]   word,
    output logic [3:0]              flags
);

    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic                    inc;
    logic [FRAC_W+1:0]       m;
    logic                    carry;
    logic [FRAC_W-1:0]       frac;
    logic signed [EXP_W+1:0] e_adj;
    logic                    ovf;
    logic                    uf;

    always_comb begin
        inc   = g & (s | mant[0]);
        m     = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, inc};
        carry = m[FRAC_W+1];
        // A rounding carry leaves 10...0, so dropping one bit renormalises it.
        frac  = carry ? m[FRAC_W:1] : m[FRAC_W-1:0];
        e_adj = e + {{(EXP_W+1){1'b0}}, carry};
        uf    = e_adj[EXP_W+1] || (e_adj == '0);
        ovf   = !uf && (e_adj[EXP_W:0] >= EXP_MAX);

        flags          = '0;
        flags[FLG_INX] = g | s;
        if (ovf) begin
            word           = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags[FLG_OVF] = 1'b1;
        end else if (uf) begin
            word           = {sign, {(EXP_W+FRAC_W){1'b0}}};
            flags[FLG_UF]  = 1'b1;
        end else begin
            word           = {sign, e_adj[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/float_normalize.sv
// Post-add normalise/round: one mantissa shift per cycle, then RNE round and pack.
// Latency n+2 edges for n shifts (1 for zero); single operation in flight, in_ready only in IDLE.
module float_normalize
    import float_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int IN_W   = IN_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    float_normalize_if.slave   bus
);

    localparam int W = 1 + EXP_W + FRAC_W;
    localparam logic signed [EXP_W+1:0] E_ONE = {{(EXP_W+1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic                    sign;
    logic [IN_W-1:0]         mag;
    logic signed [EXP_W+1:0] e;
    logic                    g;
    logic                    s;
    logic [W-1:0]            out_q;
    logic [3:0]              flags_q;

    logic                    mag_zero;
    logic                    need_right;
    logic                    need_left;
    logic [W-1:0]            rp_word;
    logic [3:0]              rp_flags;

    always_comb begin
        mag_zero   = (mag == '0);
        need_right = |mag[IN_W-1:FRAC_W+1];
        need_left  = !mag[FRAC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.in_valid) state_nxt = NORM;
            NORM:  if (mag_zero) state_nxt = DONE;
                   else if (!need_right && !need_left) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out       = out_q;
        bus.out_flags = flags_q;
    end

    // Once a right shift clears the upper bits the hidden bit sits at FRAC_W,
    // so a left shift can never follow within the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign    <= 1'b0;
            mag     <= '0;
            e       <= '0;
            g       <= 1'b0;
            s       <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign <= bus.in_mant[IN_W-1];
                        mag  <= bus.in_mant[IN_W-1] ?
                                (~bus.in_mant) + {{(IN_W-1){1'b0}}, 1'b1} : bus.in_mant;
                        e    <= {2'b00, bus.in_exp};
                        g    <= 1'b0;
                        s    <= 1'b0;
                    end
                end
                NORM: begin
                    if (mag_zero) begin
                        out_q             <= '0;
                        flags_q           <= '0;
                        flags_q[FLG_ZERO] <= 1'b1;
                    end else if (need_right) begin
                        s   <= s | g;
                        g   <= mag[0];
                        mag <= {1'b0, mag[IN_W-1:1]};
                        e   <= e + E_ONE;
                    end else if (need_left) begin
                        mag <= {mag[IN_W-2:0], 1'b0};
                        e   <= e - E_ONE;
                    end
                end
                ROUND: begin
                    out_q   <= rp_word;
                    flags_q <= rp_flags;
                end
                default: ;
            endcase
        end
    end

    float_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .sign  (sign),
        .e     (e),
        .mant  (mag[FRAC_W:0]),
        .g     (g),
        .s     (s),
        .word  (rp_word),
        .flags (rp_flags)
    );

endmodule

// File: tb/tb_float_normalize.sv
// Directed bench for float_normalize: scoreboard of expected word/flags/latency per operation.
module tb_float_normalize;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    float_normalize_if bus ();

    float_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operation, measure edges from accept to out_valid, compare against scoreboard.
    task automatic send(input string tag, input logic [7:0] ex, input logic [31:0] m,
                        input logic [31:0] ew, input logic [3:0] ef, input int elat,
                        input bit consume);
        exp_t x;
        int   n;
        int   edges;
        sb.push_back('{ew, ef, elat});
        @(negedge clk);
        bus.in_exp   = ex;
        bus.in_mant  = m;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        x = sb.pop_front();
        check({tag, "_lat"},   edges,                 x.lat);
        check({tag, "_out"},   bus.out,               x.word);
        check({tag, "_flags"}, {28'd0, bus.out_flags}, {28'd0, x.flags});
        if (consume) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] held;
        bus.in_valid  = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out",       bus.out,                32'd0);
        check("rst_flags",     {28'd0, bus.out_flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send("one",      8'd127, 32'h0080_0000, 32'h3F80_0000, 4'b0000, 2,  1'b1);
        send("two",      8'd127, 32'h0100_0000, 32'h4000_0000, 4'b0000, 3,  1'b1);
        send("neg_two",  8'd128, 32'hFF80_0000, 32'hC000_0000, 4'b0000, 2,  1'b1);
        send("left23",   8'd150, 32'h0000_0001, 32'h3F80_0000, 4'b0000, 25, 1'b1);
        send("tie_even", 8'd127, 32'h0180_0001, 32'h4040_0000, 4'b1000, 3,  1'b1);
        send("round_up", 8'd127, 32'h0180_0003, 32'h4040_0002, 4'b1000, 3,  1'b1);
        send("rnd_carry",8'd127, 32'h01FF_FFFF, 32'h4080_0000, 4'b1000, 3,  1'b1);
        send("overflow", 8'd254, 32'h0100_0000, 32'h7F80_0000, 4'b0010, 3,  1'b1);
        send("underflow",8'd1,   32'h0040_0000, 32'h0000_0000, 4'b0100, 3,  1'b1);
        send("zero",     8'd100, 32'h0000_0000, 32'h0000_0000, 4'b0001, 1,  1'b1);
        send("min_neg",  8'd127, 32'h8000_0000, 32'hC380_0000, 4'b0000, 10, 1'b1);

        bus.out_ready = 1'b0;
        send("stall", 8'd127, 32'h0100_0000, 32'h4000_0000, 4'b0000, 3, 1'b0);
        held = bus.out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_out",   bus.out,                held);
            check("stall_ready", {31'd0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("after_hs_ready", {31'd0, bus.in_ready}, 32'd1);
        check("after_hs_out",   bus.out,               32'h4000_0000);

        @(negedge clk);
        bus.in_exp   = 8'd150;
        bus.in_mant  = 32'h0000_0001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out",   bus.out,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ready", {31'd0, bus.in_ready},  32'd1);
        check("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("postrst_no_out", {31'd0, bus.out_valid}, 32'd0);

        send("post_rst_op", 8'd127, 32'h0080_0000, 32'h3F80_0000, 4'b0000, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
